// File: rtl/wb_arb.sv
// Two-requester writeback arbiter for a 32-entry register file, with a one-cycle registered write port.
// Round-robin by default; define WB_ARB_FIXPRI_EN to make requester 0 win every tie.
module wb_arb #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  output logic [31:0]     wr_en,
  output logic [XLEN-1:0] wr_data,
  output logic            wr_src,
  output logic            conflict
);

`ifndef WB_ARB_FIXPRI_EN
  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } rr_ptr_e;

  rr_ptr_e rr_ptr_q, rr_ptr_d;
`endif

  logic            grant0, grant1, transfer;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            sel_src;

  logic [31:0]     wr_en_q, wr_en_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic            wr_src_q, wr_src_d;
  logic            conflict_q, conflict_d;

  // Grants look only at stall, the valids and the pointer, never at rd/data.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!stall) begin
      if (req0_valid && req1_valid) begin
`ifdef WB_ARB_FIXPRI_EN
        grant0 = 1'b1;
`else
        grant0 = (rr_ptr_q == PTR_REQ0);
        grant1 = (rr_ptr_q == PTR_REQ1);
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign transfer   = grant0 || grant1;

  always_comb begin
    sel_rd   = grant1 ? req1_rd   : req0_rd;
    sel_data = grant1 ? req1_data : req0_data;
    sel_src  = grant1;

    // Bit 0 is never written: an x0 destination leaves wr_en all-zero.
    wr_en_d = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      wr_en_d[i] = transfer && (sel_rd == 5'(i));
    end

    wr_data_d  = transfer ? sel_data : wr_data_q;
    wr_src_d   = transfer ? sel_src  : wr_src_q;
    conflict_d = !stall && req0_valid && req1_valid;

`ifndef WB_ARB_FIXPRI_EN
    rr_ptr_d = rr_ptr_q;
    if (grant0) begin
      rr_ptr_d = PTR_REQ1;
    end else if (grant1) begin
      rr_ptr_d = PTR_REQ0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= 1'b0;
      conflict_q <= 1'b0;
`ifndef WB_ARB_FIXPRI_EN
      rr_ptr_q   <= PTR_REQ0;
`endif
    end else begin
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
      conflict_q <= conflict_d;
`ifndef WB_ARB_FIXPRI_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;
  assign conflict = conflict_q;

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 Parameter XLEN, default 32, width of writeback data.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port stall  input  1  register file cannot take a write this cycle; blocks all grants.
REQ-005 Port req0_valid  input  1  requester 0 (ALU writeback) holds a write.
REQ-006 Port req0_rd  input  5  requester 0 destination register index.
REQ-007 Port req0_data  input  XLEN  requester 0 write data.
REQ-008 Port req0_ready  output  1  requester 0 granted this cycle; combinational.
REQ-009 Port req1_valid  input  1  requester 1 (LSU writeback) holds a write.
REQ-010 Port req1_rd  input  5  requester 1 destination register index.
REQ-011 Port req1_data  input  XLEN  requester 1 write data.
REQ-012 Port req1_ready  output  1  requester 1 granted this cycle; combinational.
REQ-013 Port wr_en  output  32  one-hot register-file write enables, bit n writes xn; registered.
REQ-014 Port wr_data  output  XLEN  write data for the asserted wr_en bit; registered.
REQ-015 Port wr_src  output  1  index of the requester that produced the current write; registered.
REQ-016 Port conflict  output  1  registered pulse: previous cycle had both requesters valid and one was made to wait.

Function
REQ-017 A transfer on requester i occurs in a cycle where reqi_valid and reqi_ready are both 1.
REQ-018 With stall=1, req0_ready and req1_ready are 0 regardless of valid or pointer.
REQ-019 With stall=0 and exactly one valid, that requester's ready is 1 and the other's is 0.
REQ-020 With stall=0 and both valid, ready goes to requester 0 if rr_ptr=0, else requester 1; never both.
REQ-021 rr_ptr (1 bit, internal) updates on every transfer to the complement of the granted index; holds otherwise.
REQ-022 Ready depends only on stall, valids and rr_ptr; it never depends on the requester's rd or data.
REQ-023 Latency 1: the cycle after a transfer, wr_en equals the 5-to-32 one-hot decode of the granted rd, wr_data equals its data, wr_src equals its index.
REQ-024 Transfer with rd=0: the cycle after, wr_en is all-zero (x0 write dropped); wr_data and wr_src still update; rr_ptr still updates.
REQ-025 Cycle with no transfer: the cycle after, wr_en is all-zero; wr_data and wr_src hold their previous values.
REQ-026 wr_en never has more than one bit set.
REQ-027 conflict is 1 in the cycle after a cycle with stall=0, req0_valid=1 and req1_valid=1; 0 otherwise.
REQ-028 stall asserted while a write is already registered does not cancel or extend that write; wr_en still pulses for exactly one cycle.
REQ-029 A requester that stays valid and is not granted keeps its rd and data stable until granted; the block does not check this.

Reset
REQ-030 While rst_n=0, regardless of clk: wr_en=0, wr_data=0, wr_src=0, conflict=0, rr_ptr=0.
REQ-031 Reset during a transfer cycle discards it; after rst_n rises, the first grant follows REQ-019/020 with rr_ptr=0.

Configuration
REQ-032 Macro WB_ARB_FIXPRI_EN defined: fixed priority, requester 0 wins whenever both are valid; rr_ptr is not implemented; all other behaviour unchanged.
REQ-033 Macro WB_ARB_FIXPRI_EN undefined: round-robin per REQ-020/021.

Verification
REQ-034 Reset, then req0_valid=1, rd=5, data=0x1234 with stall=0 -> req0_ready=1 same cycle; next cycle wr_en=0x00000020, wr_data=0x1234, wr_src=0.
REQ-035 Both valid for 4 cycles (rd0=1, rd1=2), stall=0 -> grants 0,1,0,1; wr_en 0x2,0x4,0x2,0x4 one cycle later; conflict=1 each following cycle. With WB_ARB_FIXPRI_EN: grants 0,0,0,0.
REQ-036 req1_valid=1, rd=0, data=0xFFFF -> next cycle wr_en=0, wr_data=0xFFFF, wr_src=1.
REQ-037 Both valid with stall=1 for 3 cycles, then stall=0 -> no ready and wr_en=0 during stall; first grant after stall goes to rr_ptr requester.
REQ-038 rst_n driven low asynchronously mid-cycle while wr_en=0x8 -> wr_en, wr_data, conflict go to 0 immediately; after release, both valid -> requester 0 granted.
